// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared constants, segment codes and scan states for the 7-segment scanner
package seven_segment_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Segment order is {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_digit_to_seven_segment.sv
// rtl/bcd_digit_to_seven_segment.sv - combinational BCD digit to {a..g} segment decoder
module bcd_digit_to_seven_segment
  import seven_segment_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [6:0]       o_segments
);

  // Codes 10..15 are not valid BCD and render dark
  always_comb begin
    o_segments = SEG_BLANK;
    case (i_digit)
      4'd0: o_segments = SEG_0;
      4'd1: o_segments = SEG_1;
      4'd2: o_segments = SEG_2;
      4'd3: o_segments = SEG_3;
      4'd4: o_segments = SEG_4;
      4'd5: o_segments = SEG_5;
      4'd6: o_segments = SEG_6;
      4'd7: o_segments = SEG_7;
      4'd8: o_segments = SEG_8;
      4'd9: o_segments = SEG_9;
      default: o_segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - time-multiplexed BCD 7-segment display scanner
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [BCD_W*DIGITS-1:0] i_bcd,
  input  logic                    i_load,
  output logic [6:0]              o_segments,
  output logic [DIGITS-1:0]       o_anodes,
  output logic                    o_frame_start
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  scan_state_t               r_state;
  scan_state_t               w_next_state;
  logic [CNT_W-1:0]          r_slot_count;
  logic [CNT_W-1:0]          w_next_slot_count;
  logic [IDX_W-1:0]          r_index;
  logic [IDX_W-1:0]          w_next_index;
  logic [BCD_W*DIGITS-1:0]   r_display;
  logic [BCD_W*DIGITS-1:0]   r_shadow;
  logic                      r_pending;
  logic [6:0]                r_segments;
  logic [DIGITS-1:0]         r_anodes;
  logic                      r_frame_start;

  logic                      w_slot_wrap;
  logic                      w_index_last;
  logic                      w_frame_boundary;
  logic [BCD_W-1:0]          w_digit;
  logic [6:0]                w_decoded;
  logic                      w_blank;
  logic [6:0]                w_next_segments;
  logic [DIGITS-1:0]         w_next_anodes;

  assign w_slot_wrap      = (r_slot_count == CNT_W'(REFRESH_DIV - 1));
  assign w_index_last     = (r_index == IDX_W'(DIGITS - 1));
  assign w_frame_boundary = w_slot_wrap && w_index_last;

  // DIGITS:1 mux selecting the digit currently being scanned
  always_comb begin
    w_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_digit = r_display[i*BCD_W +: BCD_W];
      end
    end
  end

  bcd_digit_to_seven_segment u_bcd_digit_to_seven_segment (
    .i_digit    (w_digit),
    .o_segments (w_decoded)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; a digit is blank while everything above and including it is zero
  always_comb begin
    logic zero_so_far;
    zero_so_far = 1'b1;
    w_blank     = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_so_far = zero_so_far && (r_display[i*BCD_W +: BCD_W] == '0);
      if ((r_index == IDX_W'(i)) && zero_so_far) begin
        w_blank = 1'b1;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_next_slot_count = w_slot_wrap ? '0 : r_slot_count + CNT_W'(1);
    w_next_index      = r_index;
    if (w_slot_wrap) begin
      w_next_index = w_index_last ? '0 : r_index + IDX_W'(1);
    end
    w_next_state = (w_next_slot_count < CNT_W'(GAP_CYCLES)) ? ST_GAP : ST_SHOW;

    w_next_segments = SEG_BLANK;
    w_next_anodes   = '0;
    if (r_state == ST_SHOW) begin
      w_next_anodes   = DIGITS'(1) << r_index;
      w_next_segments = w_blank ? SEG_BLANK : w_decoded;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_GAP;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_slot_count  <= '0;
      r_index       <= '0;
      r_display     <= '0;
      r_shadow      <= '0;
      r_pending     <= 1'b0;
      r_segments    <= SEG_BLANK;
      r_anodes      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_slot_count  <= w_next_slot_count;
      r_index       <= w_next_index;
      r_segments    <= w_next_segments;
      r_anodes      <= w_next_anodes;
      r_frame_start <= w_frame_boundary;

      if (i_load) begin
        r_shadow <= i_bcd;
      end
      // Display only swaps at the frame boundary so a frame never mixes two values
      if (w_frame_boundary && i_load) begin
        r_display <= i_bcd;
        r_pending <= 1'b0;
      end else if (w_frame_boundary && r_pending) begin
        r_display <= r_shadow;
        r_pending <= 1'b0;
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_segments    = r_segments;
  assign o_anodes      = r_anodes;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb/tb_seven_segment_scanner.sv - scoreboard bench for seven_segment_scanner against a frame-level reference model
module tb_seven_segment_scanner;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 8;
  localparam int GAP_CYCLES  = 2;
  localparam int FRAME       = DIGITS * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic        frame_start;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .i_clock       (clk),
    .i_reset       (reset),
    .i_bcd         (bcd),
    .i_load        (load),
    .o_segments    (segments),
    .o_anodes      (anodes),
    .o_frame_start (frame_start)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fs;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cycle   = 0;
  bit   running = 1'b0;

  // Reference model state: cycles since reset, displayed value, buffered load
  int          t;
  logic [15:0] disp;
  logic [15:0] sh;
  bit          pend;

  logic [6:0] seg_code [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  function automatic logic [6:0] model_seg(input logic [15:0] v, input int d);
    int dv;
    dv = int'((v >> (4 * d)) & 16'h000f);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'h0000) return 7'b0000000;
`endif
    if (dv > 9) return 7'b0000000;
    return seg_code[dv];
  endfunction

  task automatic step(input bit rst, input bit ld, input logic [15:0] b);
    exp_t e;
    int   p;
    int   dg;
    bit   bnd;
    reset = rst;
    load  = ld;
    bcd   = b;
    e.cyc = cycle;
    e.seg = 7'b0000000;
    e.an  = 4'b0000;
    e.fs  = 1'b0;
    if (rst) begin
      t    = 0;
      disp = 16'h0000;
      sh   = 16'h0000;
      pend = 1'b0;
    end else begin
      p    = t % REFRESH_DIV;
      dg   = (t / REFRESH_DIV) % DIGITS;
      bnd  = (p == REFRESH_DIV - 1) && (dg == DIGITS - 1);
      e.fs = bnd;
      if (p >= GAP_CYCLES) begin
        e.an  = 4'(1 << dg);
        e.seg = model_seg(disp, dg);
      end
      if (ld && bnd) begin
        disp = b;
        pend = 1'b0;
      end else if (ld) begin
        sh   = b;
        pend = 1'b1;
      end else if (bnd && pend) begin
        disp = sh;
        pend = 1'b0;
      end
      t++;
    end
    q.push_back(e);
    cycle++;
    @(negedge clk);
  endtask

  task automatic idle_until(input int pos);
    while ((t % FRAME) != pos) step(1'b0, 1'b0, 16'h0000);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (running) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at time %0t: no expected entry", $time);
      end else begin
        e = q.pop_front();
        checks++;
        if (segments !== e.seg) begin
          errors++;
          $display("FAIL segments cycle %0d: got %b expected %b", e.cyc, segments, e.seg);
        end
        checks++;
        if (anodes !== e.an) begin
          errors++;
          $display("FAIL anodes cycle %0d: got %b expected %b", e.cyc, anodes, e.an);
        end
        checks++;
        if (frame_start !== e.fs) begin
          errors++;
          $display("FAIL frame_start cycle %0d: got %b expected %b", e.cyc, frame_start, e.fs);
        end
      end
    end
  end

  initial begin
    int r;
    reset   = 1'b1;
    load    = 1'b0;
    bcd     = 16'h0000;
    running = 1'b1;

    repeat (3) step(1'b1, 1'b0, 16'h0000);
    repeat (FRAME + 8) step(1'b0, 1'b0, 16'h0000);

    idle_until(10);
    step(1'b0, 1'b1, 16'h1234);
    repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0000);

    idle_until(5);
    step(1'b0, 1'b1, 16'h9999);
    idle_until(FRAME - 1);
    step(1'b0, 1'b1, 16'h5678);
    repeat (FRAME + 4) step(1'b0, 1'b0, 16'h0000);

    idle_until(3);
    step(1'b0, 1'b1, 16'h00AF);
    repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 16'h0050);
    repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 16'h0000);
    repeat (2 * FRAME) step(1'b0, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 16'h4321);
    repeat (FRAME + 2) step(1'b0, 1'b0, 16'h0000);
    idle_until(2 * REFRESH_DIV + 4);
    step(1'b1, 1'b0, 16'h0000);
    repeat (FRAME + 4) step(1'b0, 1'b0, 16'h0000);

    repeat (800) begin
      r = $urandom_range(0, 199);
      step(r < 2, (r >= 2) && (r < 30), rand_bcd());
    end
    repeat (FRAME) step(1'b0, 1'b0, 16'h0000);

    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
